arp_sequencer: RTL and testbench

- Parametrised N-key arpeggiator that succeeds the fixed 4-key arpeggiator.
- Takes the raw key-held vector from the soc register file and emits a gated key vector that drives the Voice key_on inputs.
- Supports up, down and ping-pong orders, plus a bypass mode.
- Steps on a sample-rate tick, so one instance can cover all voices.

---
 rtl/arp_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_arp_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_sequencer.sv
// N-key arpeggiator: gates the held-key vector down to one stepping key (up/down/ping-pong) or bypasses it.
// Optional build macro ARP_GATE_GAP_EN inserts a one-tick key_on low gap after every step.
module arp_sequencer #(
    parameter int NUM_KEYS = 8,
    parameter int CNT_W    = 16
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          tick,
    input  logic                          enable,
    input  logic [1:0]                    mode,
    input  logic [CNT_W-1:0]              countermax,
    input  logic [NUM_KEYS-1:0]           keys_in,
    output logic [NUM_KEYS-1:0]           keys_out,
    output logic [$clog2(NUM_KEYS)-1:0]   step_idx,
    output logic                          step_pulse
);

    // state  | meaning
    // S_IDLE | bypass (enable=0) or nothing held; counter parked at 0
    // S_RUN  | stepping through held keys on terminal ticks
    localparam int IDX_W = $clog2(NUM_KEYS);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             dir;       // 0 = up, 1 = down (ping-pong only)
    logic [1:0]       mode_q;

    function automatic logic [IDX_W-1:0] lowest_held(input logic [NUM_KEYS-1:0] k);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (k[i]) r = IDX_W'(i);
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] highest_held(input logic [NUM_KEYS-1:0] k);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            if (k[i]) r = IDX_W'(i);
        return r;
    endfunction

    // Returns {next_dir, next_idx}; holds both when no other key qualifies.
    function automatic logic [IDX_W:0] advance(
        input logic [IDX_W-1:0]    idx,
        input logic [NUM_KEYS-1:0] k,
        input logic [1:0]          md,
        input logic                d
    );
        logic [IDX_W-1:0] nxt;
        logic             nd;
        logic             found;
        int               j;
        nxt   = idx;
        nd    = d;
        found = 1'b0;
        j     = 0;
        case (md)
            2'd1: begin
                for (int s = 1; s < NUM_KEYS; s++) begin
                    j = int'(idx) - s;
                    if (j < 0) j = j + NUM_KEYS;
                    if (!found && k[j]) begin
                        found = 1'b1;
                        nxt   = IDX_W'(j);
                    end
                end
            end
            2'd2: begin
                if (!d) begin
                    for (int i = 0; i < NUM_KEYS; i++)
                        if (!found && i > int'(idx) && k[i]) begin
                            found = 1'b1;
                            nxt   = IDX_W'(i);
                        end
                    for (int i = NUM_KEYS - 1; i >= 0; i--)
                        if (!found && i < int'(idx) && k[i]) begin
                            found = 1'b1;
                            nxt   = IDX_W'(i);
                            nd    = 1'b1;
                        end
                end else begin
                    for (int i = NUM_KEYS - 1; i >= 0; i--)
                        if (!found && i < int'(idx) && k[i]) begin
                            found = 1'b1;
                            nxt   = IDX_W'(i);
                        end
                    for (int i = 0; i < NUM_KEYS; i++)
                        if (!found && i > int'(idx) && k[i]) begin
                            found = 1'b1;
                            nxt   = IDX_W'(i);
                            nd    = 1'b0;
                        end
                end
            end
            default: begin
                for (int s = 1; s < NUM_KEYS; s++) begin
                    j = int'(idx) + s;
                    if (j >= NUM_KEYS) j = j - NUM_KEYS;
                    if (!found && k[j]) begin
                        found = 1'b1;
                        nxt   = IDX_W'(j);
                    end
                end
            end
        endcase
        return {nd, nxt};
    endfunction

    logic             any_held;
    logic             entering;
    logic             terminal;
    logic             dir_eff;
    logic             adv_dir;
    logic [IDX_W-1:0] adv_idx;
    logic [IDX_W-1:0] start_idx;
    logic [IDX_W-1:0] idx_next;
    logic [NUM_KEYS-1:0] run_out;

    // Search uses the live keys_in, so a release on a terminal tick is already excluded.
    always_comb begin
        any_held  = (keys_in != '0);
        entering  = enable && any_held && (state == S_IDLE);
        terminal  = enable && any_held && (state == S_RUN) && tick && (counter == countermax);
        dir_eff   = (mode != mode_q) ? 1'b0 : dir;
        {adv_dir, adv_idx} = advance(step_idx, keys_in, mode, dir_eff);
        start_idx = (mode == 2'd1) ? highest_held(keys_in) : lowest_held(keys_in);
        idx_next  = terminal ? adv_idx : step_idx;
        run_out   = keys_in & (NUM_KEYS'(1) << idx_next);
    end

`ifdef ARP_GATE_GAP_EN
    logic gap;
    logic gap_next;

    // Gap covers the tick interval right after a step; skipped when every tick steps.
    always_comb begin
        gap_next = 1'b0;
        if (entering || terminal)
            gap_next = (countermax != '0);
        else if (enable && any_held && state == S_RUN)
            gap_next = tick ? 1'b0 : gap;
    end

    always_ff @(posedge Clk) begin
        if (Reset) gap <= 1'b0;
        else       gap <= gap_next;
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= S_IDLE;
            counter    <= '0;
            dir        <= 1'b0;
            step_idx   <= '0;
            keys_out   <= '0;
            step_pulse <= 1'b0;
            mode_q     <= 2'd0;
        end else begin
            step_pulse <= 1'b0;
            mode_q     <= mode;
            if (!enable) begin
                state    <= S_IDLE;
                counter  <= '0;
                keys_out <= keys_in;
            end else if (!any_held) begin
                state    <= S_IDLE;
                counter  <= '0;
                keys_out <= '0;
            end else if (state == S_IDLE) begin
                state      <= S_RUN;
                step_idx   <= start_idx;
                counter    <= '0;
                dir        <= 1'b0;
                step_pulse <= 1'b1;
`ifdef ARP_GATE_GAP_EN
                keys_out   <= gap_next ? '0 : (NUM_KEYS'(1) << start_idx);
`else
                keys_out   <= NUM_KEYS'(1) << start_idx;
`endif
            end else begin
                dir <= dir_eff;
                if (tick) begin
                    if (terminal) begin
                        counter    <= '0;
                        step_idx   <= adv_idx;
                        dir        <= adv_dir;
                        step_pulse <= 1'b1;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
`ifdef ARP_GATE_GAP_EN
                keys_out <= gap_next ? '0 : run_out;
`else
                keys_out <= run_out;
`endif
            end
        end
    end

endmodule

// File: tb/tb_arp_sequencer.sv
// Bench for arp_sequencer: list-based reference model checked every cycle plus literal step sequences.
module tb_arp_sequencer;
    localparam int NK = 8;
`ifdef ARP_GATE_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        tick = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] countermax = 16'd0;
    logic [7:0]  keys_in = 8'h00;
    logic [7:0]  keys_out;
    logic [2:0]  step_idx;
    logic        step_pulse;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;
    logic [3:0] seq[$];

    arp_sequencer #(.NUM_KEYS(NK), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .tick(tick), .enable(enable), .mode(mode),
        .countermax(countermax), .keys_in(keys_in), .keys_out(keys_out),
        .step_idx(step_idx), .step_pulse(step_pulse)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
        #1;
    endtask

    // Expected step_idx values at each step_pulse, first element in the top nibble.
    task automatic chk_seq(input string name, input int n, input logic [31:0] exp);
        chk({name, "_len"}, seq.size(), n);
        for (int i = 0; i < n && i < seq.size(); i++)
            chk(name, {28'b0, seq[i]}, {28'b0, exp[4*(n-1-i) +: 4]});
    endtask

    // Reference model: held keys as a sorted list, next key found by list lookup.
    bit         m_run = 1'b0;
    int         m_idx = 0;
    bit         m_dir = 1'b0;
    int         m_cnt = 0;
    logic [1:0] m_mode_prev = 2'd0;
    bit         m_gap = 1'b0;
    bit         m_pulse = 1'b0;
    logic [7:0] m_out = 8'h00;

    task automatic m_advance(input logic [7:0] k, input logic [1:0] md);
        int above[$];
        int below[$];
        for (int i = 0; i < NK; i++)
            if (k[i]) begin
                if (i > m_idx) above.push_back(i);
                else if (i < m_idx) below.push_back(i);
            end
        case (md)
            2'd1: begin
                if (below.size() > 0) m_idx = below[$];
                else if (above.size() > 0) m_idx = above[$];
            end
            2'd2: begin
                if (!m_dir) begin
                    if (above.size() > 0) m_idx = above[0];
                    else if (below.size() > 0) begin m_idx = below[$]; m_dir = 1'b1; end
                end else begin
                    if (below.size() > 0) m_idx = below[$];
                    else if (above.size() > 0) begin m_idx = above[0]; m_dir = 1'b0; end
                end
            end
            default: begin
                if (above.size() > 0) m_idx = above[0];
                else if (below.size() > 0) m_idx = below[0];
            end
        endcase
    endtask

    always @(posedge Clk) begin
        int held[$];
        logic [7:0] oh;
        held.delete();
        for (int i = 0; i < NK; i++) if (keys_in[i]) held.push_back(i);
        if (Reset) begin
            m_run = 0; m_idx = 0; m_dir = 0; m_cnt = 0; m_mode_prev = 0;
            m_gap = 0; m_pulse = 0; m_out = 8'h00;
        end else begin
            m_pulse = 0;
            if (!enable) begin
                m_run = 0; m_cnt = 0; m_gap = 0; m_out = keys_in;
            end else if (held.size() == 0) begin
                m_run = 0; m_cnt = 0; m_gap = 0; m_out = 8'h00;
            end else if (!m_run) begin
                m_run = 1; m_cnt = 0; m_dir = 0; m_pulse = 1;
                m_idx = (mode == 2'd1) ? held[$] : held[0];
                m_gap = GAP && (countermax != 0);
                oh = 8'b1 << m_idx;
                m_out = m_gap ? 8'h00 : oh;
            end else begin
                if (mode != m_mode_prev) m_dir = 0;
                if (tick) begin
                    if (m_cnt == int'(countermax)) begin
                        m_cnt = 0;
                        m_advance(keys_in, mode);
                        m_pulse = 1;
                        m_gap = GAP && (countermax != 0);
                    end else begin
                        m_cnt++;
                        m_gap = 0;
                    end
                end
                oh = 8'b1 << m_idx;
                m_out = m_gap ? 8'h00 : (oh & keys_in);
            end
            m_mode_prev = mode;
        end
    end

    always @(negedge Clk) begin
        if (chk_on) begin
            chk("keys_out", {24'b0, keys_out}, {24'b0, m_out});
            chk("step_idx", {29'b0, step_idx}, m_idx);
            chk("step_pulse", {31'b0, step_pulse}, {31'b0, m_pulse});
            if (step_pulse) seq.push_back({1'b0, step_idx});
        end
    end

    task automatic go_idle();
        enable = 1'b0; keys_in = 8'h00; tick = 1'b1;
        step(2);
    endtask

    task automatic start(input logic [1:0] md, input logic [15:0] cm, input logic [7:0] k);
        mode = md; countermax = cm; keys_in = k; enable = 1'b1; tick = 1'b1;
        seq.delete();
    endtask

    initial begin
        step(1);
        chk_on = 1'b1;
        step(1);
        chk("rst_keys_out", {24'b0, keys_out}, 32'h0);
        chk("rst_step_idx", {29'b0, step_idx}, 32'h0);
        chk("rst_step_pulse", {31'b0, step_pulse}, 32'h0);

        Reset = 1'b0; enable = 1'b0; keys_in = 8'hA5;
        step(1);
        chk("bypass_out", {24'b0, keys_out}, 32'hA5);
        seq.delete();
        step(4);
        chk_seq("bypass_pulses", 0, 32'h0);

        go_idle();
        start(2'd0, 16'd2, 8'b0010_0110);
        step(10);
        chk_seq("up_seq", 4, 32'h1251);

        go_idle();
        start(2'd1, 16'd2, 8'b0010_0110);
        step(10);
        chk_seq("down_seq", 4, 32'h5215);

        go_idle();
        start(2'd2, 16'd2, 8'b0000_1011);
        step(16);
        chk_seq("pingpong_seq", 6, 32'h013101);

        go_idle();
        start(2'd0, 16'd0, 8'b0010_0110);
        step(6);
        chk_seq("cmax0_seq", 6, 32'h125125);

        go_idle();
        start(2'd0, 16'd1, 8'b0010_0110);
        for (int i = 0; i < 16; i++) begin
            tick = i[0];
            step(1);
        end
        chk_seq("tick_gate_seq", 5, 32'h12512);

        go_idle();
        start(2'd0, 16'd2, 8'h06);
        step(4);
        chk("release_pre", {24'b0, keys_out}, GAP ? 32'h0 : 32'h04);
        keys_in = 8'h02;
        step(1);
        chk("release_drop", {24'b0, keys_out}, 32'h0);
        step(2);
        chk("release_next", {24'b0, keys_out}, GAP ? 32'h0 : 32'h02);
        chk("release_pulse", {31'b0, step_pulse}, 32'h1);
        keys_in = 8'h00;
        step(1);
        chk("release_all", {24'b0, keys_out}, 32'h0);

        go_idle();
        start(2'd2, 16'd0, 8'b0000_1011);
        step(4);
        mode = 2'd0;
        step(1);
        chk("mode_change_idx", {29'b0, step_idx}, 32'h3);
        mode = 2'd3;
        step(4);
        mode = 2'd2;
        countermax = 16'd1;
        step(5);
        mode = 2'd1;
        step(5);

        go_idle();
        start(2'd0, 16'd1, 8'b0000_0101);
        step(4);
        chk("pre_reset_idx", {29'b0, step_idx}, 32'h2);
        Reset = 1'b1;
        step(1);
        chk("mid_reset_out", {24'b0, keys_out}, 32'h0);
        chk("mid_reset_idx", {29'b0, step_idx}, 32'h0);
        Reset = 1'b0; keys_in = 8'h00;
        step(2);
        chk("resume_idle", {24'b0, keys_out}, 32'h0);
        keys_in = 8'b0000_0101;
        step(1);
        chk("resume_out", {24'b0, keys_out}, GAP ? 32'h0 : 32'h01);
        chk("resume_pulse", {31'b0, step_pulse}, 32'h1);

        go_idle();
        start(2'd0, 16'd3, 8'h10);
        for (int c = 1; c <= 8; c++) begin
            step(1);
            chk("single_key", {24'b0, keys_out}, (GAP && (c % 4 == 1)) ? 32'h0 : 32'h10);
        end

        go_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
